// File: rtl/recebe_pixels.sv
// recebe_pixels: frame capture sink for the zoom pipeline.
// Receives a raster pixel stream (pixel, valid, end-of-line) and writes it
// into frame memory. It also reports protocol errors, frame completion and
// a running 16-bit checksum.
module recebe_pixels #(
   parameter int IMG_W  = 320,
   parameter int IMG_H  = 240,
   parameter int ADDR_W = 17,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valida_in,
   input  logic              line_end_in,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_en,
   output logic              busy,
   output logic              frame_done,
   output logic              overflow,
   output logic              short_line,
   output logic [15:0]       checksum
);

   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   localparam logic [COL_W-1:0]  LAST_COL = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(IMG_H - 1);
   localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMG_W);

   typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

   state_t              state_q, state_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   line_base_q, line_base_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                wr_en_q, wr_en_d;
   logic                busy_q, busy_d;
   logic                frame_done_q, frame_done_d;
   logic                overflow_q, overflow_d;
   logic                short_line_q, short_line_d;
   logic [15:0]         checksum_q, checksum_d;

   // Working copies of the counters: zero when start_in restarts the frame,
   // so a pixel arriving with start_in lands at (0,0).
   logic                clear;
   logic                accept;
   logic                wrap;
   logic [COL_W-1:0]    cur_col;
   logic [ROW_W-1:0]    cur_row;
   logic [ADDR_W-1:0]   cur_addr;
   logic [ADDR_W-1:0]   cur_base;
   logic [ADDR_W-1:0]   next_base;
   logic [15:0]         cur_sum;

   // Next-state, address generation and output computation.
   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      addr_d       = addr_q;
      line_base_d  = line_base_q;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      wr_en_d      = 1'b0;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      overflow_d   = overflow_q;
      short_line_d = short_line_q;
      checksum_d   = checksum_q;
      clear        = 1'b0;
      accept       = 1'b0;
      wrap         = 1'b0;
      next_base    = '0;

      case (state_q)
         IDLE: begin
            if (start_in) begin
               clear  = 1'b1;
               accept = data_valida_in;
            end else if (data_valida_in) begin
               overflow_d = 1'b1;
            end
         end
         CAPTURE: begin
            clear  = start_in;
            accept = data_valida_in;
         end
         DONE: begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = IDLE;
            if (start_in) begin
               clear  = 1'b1;
               accept = data_valida_in;
            end else if (data_valida_in) begin
               overflow_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase

      cur_col  = clear ? '0 : col_q;
      cur_row  = clear ? '0 : row_q;
      cur_addr = clear ? '0 : addr_q;
      cur_base = clear ? '0 : line_base_q;
      cur_sum  = clear ? '0 : checksum_q;

      if (clear) begin
         state_d      = CAPTURE;
         busy_d       = 1'b1;
         col_d        = '0;
         row_d        = '0;
         addr_d       = '0;
         line_base_d  = '0;
         checksum_d   = '0;
         overflow_d   = 1'b0;
         short_line_d = 1'b0;
      end

      if (accept) begin
         wr_en_d    = 1'b1;
         wr_addr_d  = cur_addr;
         wr_data_d  = data_in;
         checksum_d = cur_sum + 16'(data_in);
         wrap       = (cur_col == LAST_COL) || line_end_in;
         if (line_end_in && (cur_col != LAST_COL)) begin
            short_line_d = 1'b1;
         end
         if (wrap) begin
            next_base = cur_base + LINE_STEP;
            col_d     = '0;
            if (cur_row == LAST_ROW) begin
               state_d = DONE;
            end else begin
               row_d       = cur_row + 1'b1;
               line_base_d = next_base;
               addr_d      = next_base;
            end
         end else begin
            col_d  = cur_col + 1'b1;
            addr_d = cur_addr + 1'b1;
         end
      end
   end

   // State and output registers; reset returns everything to idle zeros.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         col_q        <= '0;
         row_q        <= '0;
         addr_q       <= '0;
         line_base_q  <= '0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         wr_en_q      <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         short_line_q <= 1'b0;
         checksum_q   <= '0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         addr_q       <= addr_d;
         line_base_q  <= line_base_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         wr_en_q      <= wr_en_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
         short_line_q <= short_line_d;
         checksum_q   <= checksum_d;
      end
   end

   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign wr_en      = wr_en_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;
   assign short_line = short_line_q;
   assign checksum   = checksum_q;

endmodule
